uart_rx_framer: RTL and testbench



---
 rtl/uart_pkg.sv | 17 +
 rtl/sync_fifo.sv | 69 ++++++
 rtl/uart_rx_framer.sv | 160 ++++++++++++++++
 tb/tb_uart_rx_framer.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive framer.
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StWaitIdle
  } rx_state_t;

  localparam int unsigned DATA_BITS_DEF = 8;

  // Serial line level when nothing is being sent.
  localparam logic LINE_IDLE = 1'b1;

endpackage

// File: rtl/sync_fifo.sv
// First-word fall-through FIFO with occupancy count.
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   wr_en, wr_data push request and data (accepted when not full, or when full with a pop)
//   rd_en          pop request (ignored when empty)
//   rd_data        head entry, valid while empty=0
//   full, empty    occupancy flags
//   count          number of entries held
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PtrW   = $clog2(DEPTH);
  localparam int unsigned CountW = $clog2(DEPTH+1);

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CountW-1:0] count_q;
  logic              do_push, do_pop;

  assign full  = (count_q == CountW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

  // A pop frees the slot in the same cycle, so a push at full is still taken.
  assign do_pop  = rd_en && !empty;
  assign do_push = wr_en && (!full || do_pop);

  assign rd_data = mem_q[rd_ptr_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (do_push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  // Depth is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CountW'(1);
        2'b01:   count_q <= count_q - CountW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_framer.sv
// Oversampling 8N1 receive framer with start-bit qualification, stop-bit check,
// sticky error flags and a FWFT byte buffer.
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   rx_bit      recovered serial line (idles high)
//   rd_en       pop request, ignored when rd_valid=0
//   clr_err     pulse clearing frame_err and overrun
//   rd_data     head byte of the buffer
//   rd_valid    buffer not empty
//   fifo_count  bytes held
//   frame_err   sticky: stop bit sampled low
//   overrun     sticky: good byte dropped because the buffer was full
module uart_rx_framer
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned DATA_BITS    = DATA_BITS_DEF,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            rx_bit,
  input  logic                            rd_en,
  input  logic                            clr_err,
  output logic [DATA_BITS-1:0]            rd_data,
  output logic                            rd_valid,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
  output logic                            frame_err,
  output logic                            overrun
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam int unsigned BitW = $clog2(DATA_BITS + 1);
  localparam logic [CntW-1:0] CntHalf = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);
  localparam logic [BitW-1:0] BitLast = BitW'(DATA_BITS - 1);

  rx_state_t state_q, state_d;

  logic                 sync_q, rxs_q;
  logic [CntW-1:0]      cnt_q;
  logic [BitW-1:0]      bit_cnt_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 frame_err_q, overrun_q;

  logic cnt_run, sample, shift_en, push, fe_set, ovr_set;
  logic fifo_full, fifo_empty, pop;

  assign rd_valid  = !fifo_empty;
  assign pop       = rd_en && rd_valid;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

  // Two-flop synchroniser, reset to the idle level so reset never looks like a start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= LINE_IDLE;
      rxs_q  <= LINE_IDLE;
    end else begin
      sync_q <= rx_bit;
      rxs_q  <= sync_q;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:     if (!rxs_q) state_d = StStart;
      StStart:    if (sample) state_d = rxs_q ? StIdle : StData;
      StData:     if (sample && bit_cnt_q == BitLast) state_d = StStop;
      StStop:     if (sample) state_d = rxs_q ? StIdle : StWaitIdle;
      StWaitIdle: if (rxs_q) state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  // Per-state strobes.
  always_comb begin
    cnt_run  = 1'b0;
    sample   = 1'b0;
    shift_en = 1'b0;
    push     = 1'b0;
    fe_set   = 1'b0;
    ovr_set  = 1'b0;
    unique case (state_q)
      StStart: begin
        cnt_run = 1'b1;
        sample  = (cnt_q == CntHalf);
      end
      StData: begin
        cnt_run  = 1'b1;
        sample   = (cnt_q == CntLast);
        shift_en = sample;
      end
      StStop: begin
        cnt_run = 1'b1;
        sample  = (cnt_q == CntLast);
        if (sample) begin
          if (rxs_q) begin
            // Room is judged after any pop in the same cycle.
            if (!fifo_full || pop) push    = 1'b1;
            else                   ovr_set = 1'b1;
          end else begin
            fe_set = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // Bit-period counter restarts on every sample, so each state begins at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
    end else begin
      cnt_q <= (cnt_run && !sample) ? cnt_q + CntW'(1) : '0;
      if (state_q != StData) bit_cnt_q <= '0;
      else if (shift_en)     bit_cnt_q <= bit_cnt_q + BitW'(1);
      // LSB arrives first, so shifting in at the MSB leaves it at bit 0.
      if (shift_en) shift_q <= {rxs_q, shift_q[DATA_BITS-1:1]};
    end
  end

  // Sticky flags; a set in the same cycle as clr_err wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      frame_err_q <= (frame_err_q && !clr_err) || fe_set;
      overrun_q   <= (overrun_q && !clr_err) || ovr_set;
    end
  end

  sync_fifo #(
    .WIDTH(DATA_BITS),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (push),
    .wr_data(shift_q),
    .rd_en  (rd_en),
    .rd_data(rd_data),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

endmodule

// File: tb/tb_uart_rx_framer.sv
// Scoreboard bench for uart_rx_framer at CLKS_PER_BIT=16, FIFO_DEPTH=4.
module tb_uart_rx_framer;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_bit;
  logic       rd_en;
  logic       clr_err;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic [2:0] fifo_count;
  logic       frame_err;
  logic       overrun;

  int checks   = 0;
  int failures = 0;

  logic [7:0] exp_q[$];
  bit         exp_ovr = 1'b0;
  bit         exp_fe  = 1'b0;

  always #5 clk = ~clk;

  uart_rx_framer #(
    .CLKS_PER_BIT(16),
    .DATA_BITS   (8),
    .FIFO_DEPTH  (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_bit    (rx_bit),
    .rd_en     (rd_en),
    .clr_err   (clr_err),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .fifo_count(fifo_count),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_rd_data"}, 32'(rd_data), 32'h0);
    check_eq({tag, "_rd_valid"}, 32'(rd_valid), 32'h0);
    check_eq({tag, "_count"}, 32'(fifo_count), 32'h0);
    check_eq({tag, "_frame_err"}, 32'(frame_err), 32'h0);
    check_eq({tag, "_overrun"}, 32'(overrun), 32'h0);
  endtask

  task automatic check_state(input string tag);
    check_eq({tag, "_count"}, 32'(fifo_count), 32'(exp_q.size()));
    check_eq({tag, "_rd_valid"}, 32'(rd_valid), 32'(exp_q.size() != 0));
    check_eq({tag, "_frame_err"}, 32'(frame_err), 32'(exp_fe));
    check_eq({tag, "_overrun"}, 32'(overrun), 32'(exp_ovr));
  endtask

  task automatic pop_byte(input string tag);
    if (exp_q.size() == 0) begin
      check_eq({tag, "_unexpected_valid"}, 32'(rd_valid), 32'h0);
    end else begin
      check_eq({tag, "_valid"}, 32'(rd_valid), 32'h1);
      check_eq({tag, "_data"}, 32'(rd_data), 32'(exp_q.pop_front()));
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
    end
  endtask

  // One 160-cycle frame. Line changes just after edge c; the stop sample is edge 155,
  // so rd_en raised at c=154 is live in the stop-sample cycle.
  task automatic send_frame(input logic [7:0] data, input bit stop_bit, input bit pop_at_stop);
    logic [9:0] frame;
    bit         popped;
    bit         first;
    frame  = {stop_bit, data, 1'b0};
    popped = 1'b0;
    first  = (exp_q.size() == 0) && stop_bit && !pop_at_stop;
    for (int c = 0; c < 160; c++) begin
      @(posedge clk);
      #1;
      rx_bit = frame[c/16];
      rd_en  = 1'b0;
      if (pop_at_stop && c == 154) begin
        if (exp_q.size() == 0) begin
          check_eq("stop_pop_unexpected_valid", 32'(rd_valid), 32'h0);
        end else begin
          check_eq("stop_pop_valid", 32'(rd_valid), 32'h1);
          check_eq("stop_pop_data", 32'(rd_data), 32'(exp_q.pop_front()));
          rd_en  = 1'b1;
          popped = 1'b1;
        end
      end
      if (first && c == 154) check_eq("valid_before_push", 32'(rd_valid), 32'h0);
      if (first && c == 155) check_eq("valid_after_push", 32'(rd_valid), 32'h1);
    end
    if (stop_bit) begin
      if (popped || exp_q.size() < 4) exp_q.push_back(data);
      else                            exp_ovr = 1'b1;
    end else begin
      exp_fe = 1'b1;
    end
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    exp_fe  = 1'b0;
    exp_ovr = 1'b0;
  endtask

  initial begin
    rst     = 1'b1;
    rx_bit  = 1'b1;
    rd_en   = 1'b0;
    clr_err = 1'b0;
    idle(3);
    check_reset_outputs("por");
    rst = 1'b0;
    idle(5);

    // Basic frame.
    send_frame(8'hFD, 1'b1, 1'b0);
    check_state("basic");
    pop_byte("basic");
    check_state("basic_drained");

    // Start-bit glitch.
    rx_bit = 1'b0;
    idle(3);
    rx_bit = 1'b1;
    idle(30);
    check_state("glitch");

    // Framing error followed by a break.
    send_frame(8'h55, 1'b0, 1'b0);
    idle(40);
    check_state("break_low");
    rx_bit = 1'b1;
    idle(10);
    check_state("break_end");
    pulse_clr();
    check_state("fe_cleared");
    send_frame(8'h5A, 1'b1, 1'b0);
    check_state("after_break");
    pop_byte("after_break");

    // Overrun with five unread frames.
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 1'b0);
    check_state("overrun");
    for (int i = 0; i < 4; i++) pop_byte("overrun_pop");
    check_state("overrun_drained");
    pulse_clr();
    check_state("ovr_cleared");

    // Push and pop together while full.
    for (int i = 0; i < 4; i++) send_frame(8'h10 + 8'(i), 1'b1, 1'b0);
    send_frame(8'hA5, 1'b1, 1'b1);
    check_state("full_push_pop");
    for (int i = 0; i < 4; i++) pop_byte("full_pop");
    check_state("full_drained");

    // Reset mid-frame with a byte buffered and an error pending.
    send_frame(8'h77, 1'b1, 1'b0);
    send_frame(8'h00, 1'b0, 1'b0);
    rx_bit = 1'b1;
    idle(5);
    rx_bit = 1'b0;
    idle(16 * 4);
    rst    = 1'b1;
    rx_bit = 1'b1;
    #1;
    check_reset_outputs("mid_rst");
    exp_q.delete();
    exp_fe  = 1'b0;
    exp_ovr = 1'b0;
    idle(2);
    check_reset_outputs("mid_rst_held");
    rst = 1'b0;
    idle(5);
    check_state("post_rst");
    send_frame(8'h3C, 1'b1, 1'b0);
    idle(20);
    check_state("post_rst_frame");
    pop_byte("post_rst");
    check_state("post_rst_drained");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
